// File: rtl/qkd_pkg.sv
// qkd_pkg: shared sizes, sift state enum and width typedefs for the key sifting path
package qkd_pkg;
  localparam int RAW_BITS = 640;
  localparam int KEY_BITS = 128;
  localparam int LANE = 8;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} sift_state_e;
  typedef logic [$clog2(KEY_BITS+1)-1:0] key_len_t;
  typedef logic [$clog2(RAW_BITS+1)-1:0] err_cnt_t;
endpackage

// File: rtl/key_sift_controller_if.sv
// key_sift_controller_if: start/abort request, sifted vectors and key valid/ready return
interface key_sift_controller_if
  import qkd_pkg::*;
#(
  parameter int RAW_BITS = qkd_pkg::RAW_BITS,
  parameter int KEY_BITS = qkd_pkg::KEY_BITS
);
  logic start;
  logic abort;
  logic [RAW_BITS-1:0] sender_vsifted;
  logic [RAW_BITS-1:0] receiver_vsifted;
  logic busy;
  logic [KEY_BITS-1:0] key;
  logic [$clog2(KEY_BITS+1)-1:0] key_len;
  logic key_short;
  logic key_valid;
  logic key_ready;
  logic [$clog2(RAW_BITS+1)-1:0] err_count;
  modport master (
    output start, abort, sender_vsifted, receiver_vsifted, key_ready,
    input  busy, key, key_len, key_short, key_valid, err_count
  );
  modport slave (
    input  start, abort, sender_vsifted, receiver_vsifted, key_ready,
    output busy, key, key_len, key_short, key_valid, err_count
  );
endinterface

// File: rtl/sift_lane_compact.sv
// sift_lane_compact: lane agreement mask, prefix offsets and room-limited match/mismatch counts (miss_o with QKD_QBER_COUNT_EN)
module sift_lane_compact #(
  parameter int LANE = 8,
  localparam int CW = $clog2(LANE+1)
) (
  input  logic [LANE-1:0]         s_i,
  input  logic [LANE-1:0]         r_i,
  input  logic [CW-1:0]           room_i,
`ifdef QKD_QBER_COUNT_EN
  output logic [CW-1:0]           miss_o,
`endif
  output logic [LANE-1:0]         match_o,
  output logic [LANE-1:0][CW-1:0] off_o,
  output logic [CW-1:0]           take_o
);
  logic [CW-1:0] acc;
  // bit i is still live while fewer than room_i matches precede it
  always_comb begin
    match_o = ~(s_i ^ r_i);
    off_o = '0;
    take_o = '0;
    acc = '0;
    for (int i = 0; i < LANE; i++) begin
      off_o[i] = acc;
      take_o = take_o + CW'(match_o[i] && acc < room_i);
      acc = acc + CW'(match_o[i]);
    end
  end
`ifdef QKD_QBER_COUNT_EN
  // mismatches only count up to the point where the key fills
  always_comb begin
    miss_o = '0;
    for (int i = 0; i < LANE; i++) miss_o = miss_o + CW'(!match_o[i] && off_o[i] < room_i);
  end
`endif
endmodule

// File: rtl/key_sift_controller.sv
// key_sift_controller: scans sifted vectors LANE bits/cycle, packs agreeing bits into the key; QKD_QBER_COUNT_EN enables err_count
module key_sift_controller
  import qkd_pkg::*;
#(
  parameter int RAW_BITS = qkd_pkg::RAW_BITS,
  parameter int KEY_BITS = qkd_pkg::KEY_BITS,
  parameter int LANE = qkd_pkg::LANE
) (
  input logic clk,
  input logic rst_n,
  key_sift_controller_if.slave bus
);
  localparam int NL = RAW_BITS / LANE;
  localparam int PW = $clog2(NL);
  localparam int KW = $clog2(KEY_BITS+1);
  localparam int CW = $clog2(LANE+1);
  localparam logic [PW-1:0] LAST = PW'(NL-1);
  sift_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [KW-1:0] fill_q, fill_d, left;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [RAW_BITS-1:0] snd_q, snd_d, rcv_q, rcv_d;
  logic [LANE-1:0] lane_s, lane_r, match;
  logic [LANE-1:0][CW-1:0] off;
  logic [CW-1:0] room, take;
  assign lane_s = snd_q[int'(ptr_q)*LANE +: LANE];
  assign lane_r = rcv_q[int'(ptr_q)*LANE +: LANE];
  assign left = KW'(KEY_BITS) - fill_q;
  assign room = left >= KW'(LANE) ? CW'(LANE) : CW'(left);
`ifdef QKD_QBER_COUNT_EN
  localparam int EW = $clog2(RAW_BITS+1);
  logic [CW-1:0] miss;
  logic [EW-1:0] err_q, err_d;
`endif
  sift_lane_compact #(.LANE(LANE)) u_lane (
    .s_i(lane_s),
    .r_i(lane_r),
    .room_i(room),
`ifdef QKD_QBER_COUNT_EN
    .miss_o(miss),
`endif
    .match_o(match),
    .off_o(off),
    .take_o(take)
  );
  // state, pointers, captured vectors and key register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      fill_q <= '0;
      key_q <= '0;
      snd_q <= '0;
      rcv_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      fill_q <= fill_d;
      key_q <= key_d;
      snd_q <= snd_d;
      rcv_q <= rcv_d;
    end
  end
  // next state: capture on start, pack live matches per lane, hold in DONE until accepted
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    fill_d = fill_q;
    key_d = key_q;
    snd_d = snd_q;
    rcv_d = rcv_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        state_d = SCAN;
        ptr_d = '0;
        fill_d = '0;
        key_d = '0;
        snd_d = bus.sender_vsifted;
        rcv_d = bus.receiver_vsifted;
      end
      SCAN: begin
        for (int i = 0; i < LANE; i++)
          if (match[i] && off[i] < room) key_d[int'(fill_q) + int'(off[i])] = lane_s[i];
        fill_d = fill_q + KW'(take);
        ptr_d = ptr_q == LAST ? ptr_q : ptr_q + PW'(1);
        state_d = (fill_d == KW'(KEY_BITS) || ptr_q == LAST) ? DONE : SCAN;
      end
      DONE: state_d = bus.key_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      ptr_d = '0;
      fill_d = '0;
      key_d = '0;
    end
  end
`ifdef QKD_QBER_COUNT_EN
  // mismatch tally: cleared on an accepted start, accumulated per scanned lane
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= '0;
    else err_q <= err_d;
  end
  // next mismatch tally
  always_comb begin
    err_d = (state_q == IDLE && bus.start && !bus.abort) ? '0 :
            (state_q == SCAN && !bus.abort) ? err_q + EW'(miss) : err_q;
  end
  assign bus.err_count = err_q;
`else
  assign bus.err_count = '0;
`endif
  assign bus.busy = state_q != IDLE;
  assign bus.key_valid = state_q == DONE;
  assign bus.key_short = state_q == DONE && fill_q < KW'(KEY_BITS);
  assign bus.key = key_q;
  assign bus.key_len = fill_q;
endmodule

// File: tb/tb_key_sift_controller.sv
// tb_key_sift_controller: directed checks of latency, packing, exhaustion, backpressure, reset and abort
module tb_key_sift_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  key_sift_controller_if bus ();
  key_sift_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [639:0] rnd();
    logic [639:0] v;
    for (int i = 0; i < 20; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_run(input logic [639:0] s, input logic [639:0] r);
    bus.sender_vsifted = s;
    bus.receiver_vsifted = r;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.key_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  logic [639:0] s, r, pat;
  logic [127:0] kexp;
  logic [9:0] e2, e3;
  int n;
  logic seen;

  initial begin
`ifdef QKD_QBER_COUNT_EN
    e2 = 10'd127;
    e3 = 10'd640;
`else
    e2 = 10'd0;
    e3 = 10'd0;
`endif
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.key_ready = 1'b0;
    bus.sender_vsifted = '0;
    bus.receiver_vsifted = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.key_valid, 0);
    chk("rst_key", bus.key, 0);
    chk("rst_len", bus.key_len, 0);
    chk("rst_short", bus.key_short, 0);
    chk("rst_err", bus.err_count, 0);
    rst_n = 1'b1;
    tick();

    s = rnd();
    start_run(s, s);
    chk("t1_busy", bus.busy, 1);
    wait_valid(n);
    chk("t1_latency", n, 16);
    chk("t1_key", bus.key, s[127:0]);
    chk("t1_len", bus.key_len, 128);
    chk("t1_short", bus.key_short, 0);
    chk("t1_err", bus.err_count, 0);
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;
    chk("t1_valid_drop", bus.key_valid, 0);
    chk("t1_idle", bus.busy, 0);
    chk("t1_key_kept", bus.key, s[127:0]);

    s = rnd();
    pat = {320{2'b10}};
    for (int j = 0; j < 128; j++) kexp[j] = s[2*j];
    start_run(s, s ^ pat);
    wait_valid(n);
    chk("t2_scan", n, 32);
    chk("t2_key", bus.key, kexp);
    chk("t2_len", bus.key_len, 128);
    chk("t2_short", bus.key_short, 0);
    chk("t2_err", bus.err_count, e2);
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;

    s = rnd();
    start_run(s, ~s);
    wait_valid(n);
    chk("t3_scan", n, 80);
    chk("t3_key", bus.key, 0);
    chk("t3_len", bus.key_len, 0);
    chk("t3_short", bus.key_short, 1);
    chk("t3_err", bus.err_count, e3);

    r = rnd();
    for (int k = 0; k < 5; k++) begin
      bus.start = (k == 2);
      bus.sender_vsifted = r;
      bus.receiver_vsifted = r;
      tick();
    end
    bus.start = 1'b0;
    chk("t4_valid_held", bus.key_valid, 1);
    chk("t4_len_held", bus.key_len, 0);
    chk("t4_short_held", bus.key_short, 1);
    chk("t4_key_held", bus.key, 0);
    chk("t4_err_held", bus.err_count, e3);
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;
    chk("t4_valid_drop", bus.key_valid, 0);
    chk("t4_idle", bus.busy, 0);

    s = rnd();
    start_run(s, s);
    for (int k = 0; k < 7; k++) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_busy", bus.busy, 0);
    chk("t5_key", bus.key, 0);
    chk("t5_len", bus.key_len, 0);
    chk("t5_valid", bus.key_valid, 0);
    rst_n = 1'b1;
    r = rnd();
    start_run(r, r);
    wait_valid(n);
    chk("t5_latency", n, 16);
    chk("t5_key_new", bus.key, r[127:0]);
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;

    s = rnd();
    start_run(s, s);
    for (int k = 0; k < 3; k++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_key", bus.key, 0);
    chk("t6_len", bus.key_len, 0);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      seen = seen | bus.key_valid;
      tick();
    end
    chk("t6_no_valid", seen, 0);

    bus.abort = 1'b1;
    start_run(s, s);
    bus.abort = 1'b0;
    chk("abort_wins_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
